mdc_issue_queue: RTL and testbench
==================================

// Module: mdc_issue_queue
// PURPOSE
//  Upstream job sequencer for the mdc (binary GCD) core. Accepts operand pairs over
//  valid/ready, buffers them in a DEPTH-entry FIFO, issues one job at a time to the
//  core, waits for core_done_i, and returns each result over valid/ready in order.
//  Enforces a cycle timeout so a stalled core cannot hang the pipeline.
// PARAMETERS
//  WIDTH      8   operand/result width in bits
//  DEPTH      4   FIFO entries; power of 2, >= 2
//  MAX_CYCLES 32  WAIT cycles allowed before timeout; >= 2
// PORTS
//  clk_i        in   1      clock, all logic on rising edge
//  rst_i        in   1      synchronous reset, active-high
//  in_valid_i   in   1      operand pair valid
//  in_ready_o   out  1      FIFO can accept (= !full; forced 0 while rst_i)
//  dtx_i        in   WIDTH  operand x
//  dty_i        in   WIDTH  operand y
//  core_start_o out  1      one-cycle job start pulse to core
//  core_enb_o   out  1      core enable, high in ISSUE and WAIT
//  core_dtx_o   out  WIDTH  operand x to core, stable ISSUE..WAIT
//  core_dty_o   out  WIDTH  operand y to core, stable ISSUE..WAIT
//  core_done_i  in   1      core result valid (sampled in WAIT only)
//  core_dt_i    in   WIDTH  core result
//  out_valid_o  out  1      result valid
//  out_ready_i  in   1      downstream accepts result
//  dt_o         out  WIDTH  GCD result
//  out_err_o    out  1      result produced by timeout (dt_o = 0)
//  count_o      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, count_o=0, all other outputs 0, timer 0.
//  Reset mid-job: pending job and FIFO contents dropped; core must be reset by system.
//  FIFO: push on in_valid_i && in_ready_o. Full blocks push even if a pop occurs in the
//   same cycle. Push+pop same cycle when not full: count_o unchanged. Pointers wrap mod DEPTH.
//  FSM: IDLE -> ISSUE -> WAIT -> OUTPUT -> IDLE.
//   IDLE: if !empty, pop head at this edge into core_dtx_o/core_dty_o; go ISSUE.
//   ISSUE (1 cycle): core_start_o=1, core_enb_o=1, timer<=0; go WAIT.
//   WAIT: core_enb_o=1; timer++ per cycle. core_done_i=1 -> dt_o<=core_dt_i,
//    out_err_o<=0, out_valid_o<=1, go OUTPUT. Else if timer==MAX_CYCLES-1 ->
//    dt_o<=0, out_err_o<=1, out_valid_o<=1, go OUTPUT. done wins on same cycle.
//   OUTPUT: dt_o/out_err_o held; on out_ready_i: out_valid_o<=0, go IDLE.
//  core_done_i ignored outside WAIT. No new pop while a job is outstanding.
//  Latency (empty FIFO, no backpressure): push edge t; pop edge t+1; core_start_o high
//   cycle t+1..t+2; out_valid_o rises the edge after core_done_i is sampled.
//  Throughput: one job per (3 + core latency) cycles minimum.
//  Results leave in push order; operands passed unmodified (no width change).
// CONFIGURATION
//  MDC_ISSUE_ZERO_BYPASS_EN defined: in IDLE, if head has dtx==0 or dty==0, pop and go
//   directly to OUTPUT with dt_o = dtx|dty (0 if both zero), out_err_o=0; no
//   core_start_o, core_enb_o stays 0. Bypass latency: out_valid_o at edge t+1 after pop.
//  Not defined: zero operands issued to core like any other pair.
// TESTING
//  (12,18), core model done after 5 cycles with 6 -> core_start_o 1 cycle, dt_o=6,
//   out_err_o=0, out_valid_o held until out_ready_i.
//  4 pushes with core stalled -> count_o=3 after first pop, fills to 4, in_ready_o=0;
//   5th pair not accepted; all 4 results returned in push order.
//  Core never asserts done -> after MAX_CYCLES=32 WAIT cycles out_valid_o=1, dt_o=0,
//   out_err_o=1; next queued job issues normally.
//  (0,9): with MDC_ISSUE_ZERO_BYPASS_EN -> dt_o=9, no core_start_o; without -> issued
//   to core, core_dtx_o=0, core_dty_o=9.
//  rst_i pulsed in WAIT with 2 entries queued -> next cycle count_o=0, out_valid_o=0,
//   core_enb_o=0, in_ready_o=1; late core_done_i ignored.
//  out_ready_i low 10 cycles in OUTPUT -> dt_o stable, no further core_start_o.

Source files
------------

// File: rtl/mdc_issue_queue.sv
// Job sequencer in front of the binary GCD core: operand FIFO, one-job-at-a-time issue,
// timeout guard and in-order result return. Optional zero-operand bypass: MDC_ISSUE_ZERO_BYPASS_EN.
module mdc_issue_queue #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 4,
   parameter int MAX_CYCLES = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [WIDTH-1:0]           dtx_i,
   input  logic [WIDTH-1:0]           dty_i,
   output logic                       core_start_o,
   output logic                       core_enb_o,
   output logic [WIDTH-1:0]           core_dtx_o,
   output logic [WIDTH-1:0]           core_dty_o,
   input  logic                       core_done_i,
   input  logic [WIDTH-1:0]           core_dt_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [WIDTH-1:0]           dt_o,
   output logic                       out_err_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(MAX_CYCLES) + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_OUTPUT = 2'd3;

   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [TW-1:0] TMR_ONE   = {{(TW-1){1'b0}}, 1'b1};
   localparam logic [TW-1:0] TMR_LAST  = TW'(MAX_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [WIDTH-1:0] mem_x_q [DEPTH];
   logic [WIDTH-1:0] mem_y_q [DEPTH];
   logic [WIDTH-1:0] mem_x_d [DEPTH];
   logic [WIDTH-1:0] mem_y_d [DEPTH];
   logic [WIDTH-1:0] cx_q, cx_d, cy_q, cy_d, dt_q, dt_d;
   logic             start_q, start_d, enb_q, enb_d, valid_q, valid_d, err_q, err_d;
   logic             push_s, pop_s;

   // A full FIFO refuses pushes even when a pop happens on the same edge.
   assign in_ready_o   = ~rst_i & (count_q != CNT_FULL);
   assign push_s       = in_valid_i & in_ready_o;
   assign core_start_o = start_q;
   assign core_enb_o   = enb_q;
   assign core_dtx_o   = cx_q;
   assign core_dty_o   = cy_q;
   assign out_valid_o  = valid_q;
   assign dt_o         = dt_q;
   assign out_err_o    = err_q;
   assign count_o      = count_q;

   // Next-state logic for the sequencer FSM, FIFO pointers and result registers.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      dt_d    = dt_q;
      err_d   = err_q;
      valid_d = valid_q;
      enb_d   = enb_q;
      start_d = 1'b0;
      pop_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != {CW{1'b0}}) begin
               pop_s = 1'b1;
               cx_d  = mem_x_q[rd_ptr_q];
               cy_d  = mem_y_q[rd_ptr_q];
`ifdef MDC_ISSUE_ZERO_BYPASS_EN
               if ((mem_x_q[rd_ptr_q] == {WIDTH{1'b0}}) || (mem_y_q[rd_ptr_q] == {WIDTH{1'b0}})) begin
                  dt_d    = mem_x_q[rd_ptr_q] | mem_y_q[rd_ptr_q];
                  err_d   = 1'b0;
                  valid_d = 1'b1;
                  state_d = S_OUTPUT;
               end else begin
                  start_d = 1'b1;
                  enb_d   = 1'b1;
                  state_d = S_ISSUE;
               end
`else
               start_d = 1'b1;
               enb_d   = 1'b1;
               state_d = S_ISSUE;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            enb_d   = 1'b1;
            timer_d = {TW{1'b0}};
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + TMR_ONE;
            if (core_done_i) begin
               dt_d    = core_dt_i;
               err_d   = 1'b0;
               valid_d = 1'b1;
               enb_d   = 1'b0;
               state_d = S_OUTPUT;
            end else if (timer_q == TMR_LAST) begin
               dt_d    = {WIDTH{1'b0}};
               err_d   = 1'b1;
               valid_d = 1'b1;
               enb_d   = 1'b0;
               state_d = S_OUTPUT;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_OUTPUT: begin
            if (out_ready_i) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_OUTPUT;
            end
         end
         default: begin
            state_d = S_IDLE;
            enb_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase

      mem_x_d  = mem_x_q;
      mem_y_d  = mem_y_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         mem_x_d[wr_ptr_q] = dtx_i;
         mem_y_d[wr_ptr_q] = dty_i;
         wr_ptr_d          = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // State registers; reset drops any pending job and the whole FIFO.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
         timer_q  <= {TW{1'b0}};
         cx_q     <= {WIDTH{1'b0}};
         cy_q     <= {WIDTH{1'b0}};
         dt_q     <= {WIDTH{1'b0}};
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         enb_q    <= 1'b0;
         start_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_x_q[i] <= {WIDTH{1'b0}};
            mem_y_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         dt_q     <= dt_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         enb_q    <= enb_d;
         start_q  <= start_d;
         mem_x_q  <= mem_x_d;
         mem_y_q  <= mem_y_d;
      end
   end
endmodule

// File: tb/tb_mdc_issue_queue.sv
// Directed bench for mdc_issue_queue with a behavioural GCD core model
// whose latency, stall and hold behaviour is steered by the stimulus.
module tb_mdc_issue_queue;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int MAX_CYCLES = 32;

   logic clk_i = 1'b0;
   logic rst_i, in_valid_i, in_ready_o, core_start_o, core_enb_o, core_done_i;
   logic out_valid_o, out_ready_i, out_err_o;
   logic [WIDTH-1:0] dtx_i, dty_i, core_dtx_o, core_dty_o, core_dt_i, dt_o;
   logic [2:0] count_o;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_cnt = 0;
   int start_cnt = 0;

   logic model_done, force_done, hold, stall, kill, busy;
   logic [WIDTH-1:0] model_dt;
   int lat, cnt;

   assign core_done_i = model_done | force_done;
   assign core_dt_i   = model_dt;

   always #5 clk_i = ~clk_i;

   mdc_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_CYCLES(MAX_CYCLES)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .dtx_i(dtx_i), .dty_i(dty_i), .core_start_o(core_start_o), .core_enb_o(core_enb_o),
      .core_dtx_o(core_dtx_o), .core_dty_o(core_dty_o), .core_done_i(core_done_i),
      .core_dt_i(core_dt_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .dt_o(dt_o), .out_err_o(out_err_o), .count_o(count_o)
   );

   always @(posedge clk_i) begin
      cyc_cnt <= cyc_cnt + 1;
      if (core_start_o) start_cnt <= start_cnt + 1;
   end

   function automatic logic [WIDTH-1:0] gcd8(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] x, y, t;
      x = a; y = b;
      while (y != 8'd0) begin
         t = x % y; x = y; y = t;
      end
      return x;
   endfunction

   // Core model: latches a job on core_start_o, counts down lat cycles, pulses done.
   initial begin
      model_done = 1'b0; model_dt = 8'd0; busy = 1'b0; cnt = 0;
      forever begin
         @(posedge clk_i); #1;
         if (kill) begin
            busy = 1'b0; model_done = 1'b0;
         end else if (busy) begin
            if (!hold) begin
               if (cnt <= 1) begin
                  model_done = 1'b1; model_dt = gcd8(core_dtx_o, core_dty_o); busy = 1'b0;
               end else cnt = cnt - 1;
            end
         end else begin
            model_done = 1'b0;
            if (core_start_o && !stall) begin busy = 1'b1; cnt = lat; end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      int n;
      @(negedge clk_i);
      in_valid_i = 1'b1; dtx_i = x; dty_i = y; n = 0;
      while (!in_ready_o && n < 100) begin @(negedge clk_i); n++; end
      check_eq("push_accept", in_ready_o, 1);
      @(negedge clk_i);
      in_valid_i = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid_o && n < 200) begin @(negedge clk_i); n++; end
      check_eq("valid_seen", out_valid_o, 1);
   endtask

   task automatic get_result(input string tag, input logic [WIDTH-1:0] exp_dt, input logic exp_err);
      wait_valid();
      check_eq({tag, "_dt"}, dt_o, exp_dt);
      check_eq({tag, "_err"}, out_err_o, exp_err);
      out_ready_i = 1'b1;
      @(negedge clk_i);
      out_ready_i = 1'b0;
      check_eq({tag, "_drop"}, out_valid_o, 0);
   endtask

   initial begin
      int c0, s0;
      rst_i = 1'b1; in_valid_i = 1'b0; dtx_i = 8'd0; dty_i = 8'd0; out_ready_i = 1'b0;
      force_done = 1'b0; hold = 1'b0; stall = 1'b0; kill = 1'b0; lat = 5;
      repeat (2) @(negedge clk_i);
      check_eq("rst_count", count_o, 0);
      check_eq("rst_valid", out_valid_o, 0);
      check_eq("rst_start", core_start_o, 0);
      check_eq("rst_enb", core_enb_o, 0);
      check_eq("rst_dt", dt_o, 0);
      check_eq("rst_ready_forced", in_ready_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);
      check_eq("ready_after_rst", in_ready_o, 1);

      // Single job, latency and output hold
      s0 = start_cnt;
      push(8'd12, 8'd18);
      @(negedge clk_i);
      check_eq("issue_start", core_start_o, 1);
      check_eq("issue_enb", core_enb_o, 1);
      check_eq("issue_dtx", core_dtx_o, 12);
      check_eq("issue_dty", core_dty_o, 18);
      @(negedge clk_i);
      check_eq("start_one_cycle", core_start_o, 0);
      check_eq("wait_enb", core_enb_o, 1);
      wait_valid();
      repeat (3) @(negedge clk_i);
      check_eq("held_valid", out_valid_o, 1);
      get_result("gcd_12_18", 8'd6, 1'b0);
      check_eq("single_start_cnt", start_cnt - s0, 1);

      // Fill the FIFO behind a held core
      hold = 1'b1;
      push(8'd12, 8'd18);
      @(negedge clk_i);
      check_eq("fill_c0", count_o, 0);
      push(8'd9, 8'd6);   check_eq("fill_c1", count_o, 1);
      push(8'd35, 8'd49); check_eq("fill_c2", count_o, 2);
      push(8'd8, 8'd20);  check_eq("fill_c3", count_o, 3);
      push(8'd14, 8'd21); check_eq("fill_c4", count_o, 4);
      check_eq("full_not_ready", in_ready_o, 0);
      @(negedge clk_i);
      in_valid_i = 1'b1; dtx_i = 8'd99; dty_i = 8'd33;
      repeat (3) @(negedge clk_i);
      check_eq("full_blocks_cnt", count_o, 4);
      check_eq("full_blocks_rdy", in_ready_o, 0);
      in_valid_i = 1'b0;
      hold = 1'b0;
      get_result("ord0", 8'd6, 1'b0);
      @(negedge clk_i);
      check_eq("count_after_pop", count_o, 3);
      get_result("ord1", 8'd3, 1'b0);
      get_result("ord2", 8'd7, 1'b0);
      get_result("ord3", 8'd4, 1'b0);
      get_result("ord4", 8'd7, 1'b0);
      check_eq("drained", count_o, 0);

      // Timeout with a stalled core, then a normal queued job
      stall = 1'b1;
      push(8'd5, 8'd10);
      @(negedge clk_i);
      check_eq("to_start", core_start_o, 1);
      c0 = cyc_cnt;
      push(8'd21, 8'd14);
      stall = 1'b0;
      wait_valid();
      check_eq("to_cycles", cyc_cnt - c0, 33);
      get_result("timeout", 8'd0, 1'b1);
      get_result("after_to", 8'd7, 1'b0);

      // Zero operand
      s0 = start_cnt;
      push(8'd0, 8'd9);
      @(negedge clk_i);
`ifdef MDC_ISSUE_ZERO_BYPASS_EN
      check_eq("zb_no_start", core_start_o, 0);
      check_eq("zb_no_enb", core_enb_o, 0);
      get_result("zero_byp", 8'd9, 1'b0);
      check_eq("zb_start_cnt", start_cnt - s0, 0);
`else
      check_eq("zero_start", core_start_o, 1);
      check_eq("zero_dtx", core_dtx_o, 0);
      check_eq("zero_dty", core_dty_o, 9);
      get_result("zero_core", 8'd9, 1'b0);
      check_eq("zero_start_cnt", start_cnt - s0, 1);
`endif

      // Reset during WAIT with two jobs queued
      hold = 1'b1;
      push(8'd12, 8'd18);
      @(negedge clk_i);
      push(8'd9, 8'd6);
      push(8'd35, 8'd49);
      check_eq("pre_rst_count", count_o, 2);
      check_eq("pre_rst_enb", core_enb_o, 1);
      rst_i = 1'b1; kill = 1'b1;
      @(negedge clk_i);
      check_eq("in_rst_ready", in_ready_o, 0);
      rst_i = 1'b0; kill = 1'b0; hold = 1'b0;
      check_eq("post_rst_count", count_o, 0);
      check_eq("post_rst_valid", out_valid_o, 0);
      check_eq("post_rst_enb", core_enb_o, 0);
      @(negedge clk_i);
      check_eq("post_rst_ready", in_ready_o, 1);
      force_done = 1'b1;
      repeat (2) @(negedge clk_i);
      force_done = 1'b0;
      check_eq("late_done_valid", out_valid_o, 0);
      check_eq("late_done_start", core_start_o, 0);
      check_eq("late_done_count", count_o, 0);

      // Long backpressure in OUTPUT with a job waiting
      push(8'd27, 8'd36);
      wait_valid();
      check_eq("bp_dt", dt_o, 9);
      s0 = start_cnt;
      push(8'd4, 8'd6);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         check_eq("bp_dt_stable", dt_o, 9);
      end
      check_eq("bp_valid", out_valid_o, 1);
      check_eq("bp_no_start", start_cnt - s0, 0);
      check_eq("bp_queued", count_o, 1);
      out_ready_i = 1'b1;
      @(negedge clk_i);
      out_ready_i = 1'b0;
      get_result("after_bp", 8'd2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
